// File: rtl/mem_l2_responder.sv
// mem_l2_responder: backing line store below the L2 controller.
// Accepts one line read, one dirty-line write-back, or a combined
// write-then-read per transaction, and answers each with a one-cycle
// ready pulse after a programmable latency.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for read/write request; accepts on the clock edge
// WR_WAIT | counting write latency; commits line on the last cycle
// RD_WAIT | counting read latency; captures line on the last cycle
// RESP    | ready_MEM_L2 high for this single cycle
// GAP     | turnaround cycle, requests ignored
module mem_l2_responder #(
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4,
  parameter int ADDR_BITS     = 10
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         read_L2_MEM,
  input  logic         write_L2_MEM,
  input  logic [7:0]   index_L2_MEM,
  input  logic [17:0]  tag_L2_MEM,
  input  logic [17:0]  write_tag_L2_MEM,
  input  logic [511:0] write_data_L2_MEM,
  output logic [511:0] read_data_MEM_L2,
  output logic         ready_MEM_L2
);

  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = (MAX_LAT < 2) ? 1 : $clog2(MAX_LAT);
  localparam int DEPTH   = 1 << ADDR_BITS;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_WAIT = 3'd1,
    RD_WAIT = 3'd2,
    RESP    = 3'd3,
    GAP     = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]   raddr_q, raddr_d;
  logic [ADDR_BITS-1:0]   waddr_q, waddr_d;
  logic [511:0]           wdata_q, wdata_d;
  logic                   rd_flag_q, rd_flag_d;
  logic [511:0]           read_data_q, read_data_d;
  logic                   ready_q, ready_d;
  logic                   mem_we;

  // Line store is deliberately left unreset; contents undefined until written.
  logic [511:0] mem [DEPTH];

  // Upper tag bits fall off in the truncation, so aliasing across them is intended.
  logic [ADDR_BITS-1:0] req_raddr;
  logic [ADDR_BITS-1:0] req_waddr;
  assign req_raddr = ADDR_BITS'({tag_L2_MEM, index_L2_MEM});
  assign req_waddr = ADDR_BITS'({write_tag_L2_MEM, index_L2_MEM});

  // Next-state, counter, latch and output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    raddr_d     = raddr_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    rd_flag_d   = rd_flag_q;
    read_data_d = read_data_q;
    mem_we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (read_L2_MEM || write_L2_MEM) begin
          raddr_d   = req_raddr;
          waddr_d   = req_waddr;
          wdata_d   = write_data_L2_MEM;
          rd_flag_d = read_L2_MEM;
          cnt_d     = '0;
          state_d   = write_L2_MEM ? WR_WAIT : RD_WAIT;
        end
      end
      WR_WAIT: begin
        if (cnt_q == CNT_W'(WRITE_LATENCY - 1)) begin
          mem_we  = 1'b1;
          cnt_d   = '0;
          state_d = rd_flag_q ? RD_WAIT : RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RD_WAIT: begin
        if (cnt_q == CNT_W'(READ_LATENCY - 1)) begin
          read_data_d = mem[raddr_q];
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP:    state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == RESP);
  end

  // Control and output registers; reset drops any uncommitted write.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      raddr_q     <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      rd_flag_q   <= 1'b0;
      read_data_q <= '0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      raddr_q     <= raddr_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      rd_flag_q   <= rd_flag_d;
      read_data_q <= read_data_d;
      ready_q     <= ready_d;
    end
  end

  // Line commit at the end of the write latency window.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[waddr_q] <= wdata_q;
    end
  end

  assign read_data_MEM_L2 = read_data_q;
  assign ready_MEM_L2     = ready_q;

endmodule
